// File: rtl/count_capture_fifo_pkg.sv
// count_capture_fifo_pkg
//   Shared definitions for the counter capture FIFO block:
//   - Wishbone register selects (decoded on adr[3:2])
//   - CTRL / STATUS bit positions and field widths
//   - trigger edge-select encodings
//   - packing helpers for the CTRL and STATUS read words
package count_capture_fifo_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_DATA   = 2'd2,
        REG_LAST   = 2'd3
    } reg_sel_e;

    typedef enum logic {
        EDGE_RISING  = 1'b0,
        EDGE_FALLING = 1'b1
    } edge_sel_e;

    localparam int unsigned COUNT_W = 16;

    // CTRL fields
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_EDGE_BIT   = 1;
    localparam int unsigned CTRL_THRESH_LSB = 8;
    localparam int unsigned THRESH_W        = 6;
    localparam int unsigned CTRL_CLEAR_BIT  = 31;

    // STATUS fields
    localparam int unsigned STATUS_LEVEL_LSB = 0;
    localparam int unsigned LEVEL_W          = 7;
    localparam int unsigned STATUS_EMPTY_BIT = 8;
    localparam int unsigned STATUS_FULL_BIT  = 9;
    localparam int unsigned STATUS_OVF_BIT   = 10;
    localparam int unsigned STATUS_UNF_BIT   = 11;

    function automatic logic [31:0] pack_ctrl(
        input logic                en,
        input edge_sel_e           edge_sel,
        input logic [THRESH_W-1:0] thresh
    );
        logic [31:0] w;
        w                                = '0;
        w[CTRL_EN_BIT]                   = en;
        w[CTRL_EDGE_BIT]                 = edge_sel;
        w[CTRL_THRESH_LSB +: THRESH_W]   = thresh;
        return w;
    endfunction

    function automatic logic [31:0] pack_status(
        input logic [LEVEL_W-1:0] level,
        input logic               empty,
        input logic               full,
        input logic               ovf,
        input logic               unf
    );
        logic [31:0] w;
        w                                = '0;
        w[STATUS_LEVEL_LSB +: LEVEL_W]   = level;
        w[STATUS_EMPTY_BIT]              = empty;
        w[STATUS_FULL_BIT]               = full;
        w[STATUS_OVF_BIT]                = ovf;
        w[STATUS_UNF_BIT]                = unf;
        return w;
    endfunction

endpackage

// File: rtl/count_capture_fifo_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with extra-MSB pointers (level = wptr - rptr).
//   clear_i has priority over push_i/pop_i and leaves the FIFO empty.
//   A push while full is accepted only if a pop happens in the same cycle.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         flush
//   push_i, din_i   write request and data
//   pop_i, dout_o   read request and head entry (show-ahead)
//   full_o, empty_o, level_o  occupancy
module sync_fifo
    import count_capture_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = COUNT_W
)(
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [LVL_W-1:0] wptr_q, wptr_d;
    logic [LVL_W-1:0] rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o = wptr_q - rptr_q;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        do_pop  = pop_i & ~empty_o;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        do_push = push_i & (~full_o | do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + LVL_W'(1);
            if (do_pop)  rptr_d = rptr_q + LVL_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between rptr and wptr
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/count_capture_fifo.sv
// count_capture_fifo
//   Captures the 16-bit counter value into a FIFO on a qualified trigger
//   edge; the management SoC drains it over Wishbone. Raises a level IRQ
//   when the fill level reaches a programmable threshold.
// Ports:
//   wb_clk_i, wb_rst_ni     clock, asynchronous active-low reset
//   count_i                 counter value to capture
//   trig_i                  asynchronous trigger input
//   wbs_*                   Wishbone slave (CTRL, STATUS, DATA, LAST at +0x0..0xC)
//   irq_o                   registered threshold interrupt
module count_capture_fifo
    import count_capture_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0010
)(
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic [COUNT_W-1:0] count_i,
    input  logic               trig_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               irq_o
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    // Trigger synchronizer and edge detector
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Control / status state
    logic                en_q,       en_d;
    edge_sel_e           edge_sel_q, edge_sel_d;
    logic [THRESH_W-1:0] thresh_q,   thresh_d;
    logic                ovf_q,      ovf_d;
    logic                unf_q,      unf_d;
    logic [COUNT_W-1:0]  last_q,     last_d;
    logic                ack_q,      ack_d;
    logic [31:0]         dat_q,      dat_d;
    logic                irq_q,      irq_d;

    // Datapath
    logic                edge_hit;
    logic                push_req;
    logic                pop_req;
    logic                wb_valid;
    logic                acc;
    logic                wr;
    logic                rd;
    reg_sel_e            reg_sel;
    logic                clear;
    logic                data_rd;
    logic [31:0]         rdata;
    logic [LEVEL_W-1:0]  level7;

    logic [COUNT_W-1:0]  fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LVL_W-1:0]    fifo_level;

    logic                unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[2], wbs_dat_i};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (COUNT_W)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .clear_i (clear),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .din_i   (count_i),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        sync1_d = trig_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        edge_hit = (edge_sel_q == EDGE_FALLING) ? (~sync2_q & prev_q)
                                                : (sync2_q & ~prev_q);
        // Gating with en drops any edge still in the synchronizer when disabled
        push_req = en_q & edge_hit;

        wb_valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
        // The access takes effect on the edge that raises ack
        acc      = wb_valid & ~ack_q;
        wr       = acc & wbs_we_i;
        rd       = acc & ~wbs_we_i;
        reg_sel  = reg_sel_e'(wbs_adr_i[3:2]);

        clear    = wr && (reg_sel == REG_CTRL) && wbs_sel_i[3] && wbs_dat_i[CTRL_CLEAR_BIT];
        data_rd  = rd && (reg_sel == REG_DATA);
        pop_req  = data_rd & ~fifo_empty;

        level7   = LEVEL_W'(fifo_level);

        case (reg_sel)
            REG_CTRL:   rdata = pack_ctrl(en_q, edge_sel_q, thresh_q);
            REG_STATUS: rdata = pack_status(level7, fifo_empty, fifo_full, ovf_q, unf_q);
            REG_DATA:   rdata = fifo_empty ? '0 : {16'h0, fifo_dout};
            REG_LAST:   rdata = {16'h0, last_q};
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        en_d       = en_q;
        edge_sel_d = edge_sel_q;
        thresh_d   = thresh_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        last_d     = last_q;

        if (wr && (reg_sel == REG_CTRL)) begin
            if (wbs_sel_i[0]) begin
                en_d       = wbs_dat_i[CTRL_EN_BIT];
                edge_sel_d = edge_sel_e'(wbs_dat_i[CTRL_EDGE_BIT]);
            end
            if (wbs_sel_i[1]) begin
                thresh_d = wbs_dat_i[CTRL_THRESH_LSB +: THRESH_W];
            end
        end

        if (wr && (reg_sel == REG_STATUS) && wbs_sel_i[1]) begin
            if (wbs_dat_i[STATUS_OVF_BIT]) ovf_d = 1'b0;
            if (wbs_dat_i[STATUS_UNF_BIT]) unf_d = 1'b0;
        end

        // New events win over a same-cycle W1C; clear wins over everything
        if (data_rd && fifo_empty) unf_d = 1'b1;
        if (push_req && fifo_full && !pop_req) ovf_d = 1'b1;
        if (clear) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        if (push_req) last_d = count_i;

        ack_d = acc;
        dat_d = rd ? rdata : '0;
        irq_d = en_q && (thresh_q != '0) && (level7 >= {1'b0, thresh_q});
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            en_q       <= 1'b0;
            edge_sel_q <= EDGE_RISING;
            thresh_q   <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            last_q     <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            en_q       <= en_d;
            edge_sel_q <= edge_sel_d;
            thresh_q   <= thresh_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            last_q     <= last_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
module tb_count_capture_fifo;

    localparam logic [31:0] A_CTRL   = 32'h3000_0010;
    localparam logic [31:0] A_STATUS = 32'h3000_0014;
    localparam logic [31:0] A_DATA   = 32'h3000_0018;
    localparam logic [31:0] A_LAST   = 32'h3000_001C;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic [15:0] count_i;
    logic        trig_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        irq_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    count_capture_fifo #(
        .DEPTH     (8),
        .ADDR_BASE (32'h3000_0010)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .count_i   (count_i),
        .trig_i    (trig_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .irq_o     (irq_o)
    );

    // Bus tasks are entered away from the rising edge and return just after a falling edge
    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        bit got;
        got = 0;
        d   = '0;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = a;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin got = 1; d = wbs_dat_o; end
        end
        if (!got) begin
            tests_run++; tests_failed++;
            $display("FAIL wb_read_ack: adr %h no ack, required ack within 4 clocks", a);
        end
        @(negedge wb_clk_i);
        wbs_cyc_i = 0; wbs_stb_i = 0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit got;
        got = 0;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = s; wbs_adr_i = a; wbs_dat_i = d;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) got = 1;
        end
        if (!got) begin
            tests_run++; tests_failed++;
            $display("FAIL wb_write_ack: adr %h no ack, required ack within 4 clocks", a);
        end
        @(negedge wb_clk_i);
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    endtask

    // Full trigger pulse: high for 3 clocks, then low for 3 clocks
    task automatic trig_event(input logic [15:0] v);
        count_i = v; trig_i = 1;
        repeat (3) @(negedge wb_clk_i);
        trig_i = 0;
        repeat (3) @(negedge wb_clk_i);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        for (int i = 0; i < 6; i++) begin
            @(negedge wb_clk_i);
            trig_i = ~trig_i;
            wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = A_STATUS;
            @(posedge wb_clk_i); #1;
            tests_run++;
            if (wbs_ack_o !== 1'b0 || irq_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_outputs: ack=%b irq=%b dat=%h, required 0/0/0", wbs_ack_o, irq_o, wbs_dat_o);
            end
        end
        @(negedge wb_clk_i);
        wbs_cyc_i = 0; wbs_stb_i = 0; trig_i = 0; wb_rst_ni = 1;
        repeat (3) @(negedge wb_clk_i);

        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = 32'h3000_0020;
        for (int i = 0; i < 3; i++) begin
            @(posedge wb_clk_i); #1;
            tests_run++;
            if (wbs_ack_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL out_of_range_ack: ack=%b, required 0", wbs_ack_o);
            end
        end
        @(negedge wb_clk_i);
        wbs_cyc_i = 0; wbs_stb_i = 0;

        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h100) begin tests_failed++; $display("FAIL reset_status: got %h required %h", rd, 32'h100); end
        wb_read(A_CTRL, rd);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %h required %h", rd, 32'h0); end
        wb_read(A_LAST, rd);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_last: got %h required %h", rd, 32'h0); end
    endtask

    task automatic test_single_capture();
        logic [31:0] rd;
        wb_write(A_CTRL, 32'h0000_0101, 4'hF);      // en, rising, thresh=1
        count_i = 16'h1234; trig_i = 1;
        // Push lands on the 3rd edge, so the registered irq shows it on the 4th
        for (int i = 1; i <= 3; i++) begin
            @(negedge wb_clk_i);
            tests_run++;
            if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL latency_early clk%0d: irq=%b required 0", i, irq_o); end
        end
        @(negedge wb_clk_i);
        tests_run++;
        if (irq_o !== 1'b1) begin tests_failed++; $display("FAIL latency_push: irq=%b required 1", irq_o); end
        trig_i = 0;
        repeat (3) @(negedge wb_clk_i);

        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h001) begin tests_failed++; $display("FAIL single_status: got %h required %h", rd, 32'h001); end
        wb_read(A_DATA, rd);
        tests_run++;
        if (rd !== 32'h1234) begin tests_failed++; $display("FAIL single_data: got %h required %h", rd, 32'h1234); end
        @(negedge wb_clk_i);
        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h100) begin tests_failed++; $display("FAIL single_status_after: got %h required %h", rd, 32'h100); end
        tests_run++;
        if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL single_irq_after: irq=%b required 0", irq_o); end
        wb_write(A_CTRL, 32'h0000_0001, 4'hF);      // en, rising, thresh=0
    endtask

    task automatic test_overflow_underflow();
        logic [31:0] rd;
        for (int i = 1; i <= 9; i++) trig_event(16'(i));
        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h608) begin tests_failed++; $display("FAIL ovf_status: got %h required %h", rd, 32'h608); end
        wb_read(A_LAST, rd);
        tests_run++;
        if (rd !== 32'h9) begin tests_failed++; $display("FAIL ovf_last: got %h required %h", rd, 32'h9); end
        for (int i = 1; i <= 8; i++) begin
            wb_read(A_DATA, rd);
            tests_run++;
            if (rd !== 32'(i)) begin tests_failed++; $display("FAIL drain_order[%0d]: got %h required %h", i, rd, 32'(i)); end
        end
        wb_read(A_DATA, rd);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL empty_read: got %h required %h", rd, 32'h0); end
        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'hD00) begin tests_failed++; $display("FAIL unf_status: got %h required %h", rd, 32'hD00); end
        wb_write(A_STATUS, 32'h0000_0C00, 4'b0010);
        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h100) begin tests_failed++; $display("FAIL w1c_status: got %h required %h", rd, 32'h100); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] rd;
        for (int i = 0; i < 8; i++) trig_event(16'h10 + 16'(i));
        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h208) begin tests_failed++; $display("FAIL full_status: got %h required %h", rd, 32'h208); end
        count_i = 16'h18; trig_i = 1;
        repeat (2) @(negedge wb_clk_i);
        wb_read(A_DATA, rd);                        // ack edge coincides with the push
        trig_i = 0;
        repeat (3) @(negedge wb_clk_i);
        tests_run++;
        if (rd !== 32'h10) begin tests_failed++; $display("FAIL pushpop_data: got %h required %h", rd, 32'h10); end
        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h208) begin tests_failed++; $display("FAIL pushpop_status: got %h required %h", rd, 32'h208); end
        for (int i = 1; i <= 8; i++) begin
            wb_read(A_DATA, rd);
            tests_run++;
            if (rd !== 32'h10 + 32'(i)) begin tests_failed++; $display("FAIL pushpop_drain[%0d]: got %h required %h", i, rd, 32'h10 + 32'(i)); end
        end
    endtask

    task automatic test_irq_threshold();
        logic [31:0] rd;
        wb_write(A_CTRL, 32'h0000_0301, 4'hF);      // en, rising, thresh=3
        trig_event(16'h21);
        trig_event(16'h22);
        tests_run++;
        if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL irq_below: irq=%b required 0", irq_o); end
        count_i = 16'h23; trig_i = 1;
        repeat (3) @(negedge wb_clk_i);
        tests_run++;
        if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL irq_same_clk: irq=%b required 0", irq_o); end
        @(negedge wb_clk_i);
        tests_run++;
        if (irq_o !== 1'b1) begin tests_failed++; $display("FAIL irq_rise: irq=%b required 1", irq_o); end
        trig_i = 0;
        repeat (3) @(negedge wb_clk_i);
        wb_read(A_DATA, rd);
        tests_run++;
        if (rd !== 32'h21) begin tests_failed++; $display("FAIL irq_pop_data: got %h required %h", rd, 32'h21); end
        tests_run++;
        if (irq_o !== 1'b1) begin tests_failed++; $display("FAIL irq_hold: irq=%b required 1", irq_o); end
        @(negedge wb_clk_i);
        tests_run++;
        if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL irq_fall: irq=%b required 0", irq_o); end
    endtask

    task automatic test_clear_coincident();
        logic [31:0] rd;
        wb_write(A_CTRL, 32'h8000_0301, 4'hF);
        wb_read(A_DATA, rd);
        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h900) begin tests_failed++; $display("FAIL clr_pre_status: got %h required %h", rd, 32'h900); end
        for (int i = 0; i < 4; i++) trig_event(16'h40 + 16'(i));
        tests_run++;
        if (irq_o !== 1'b1) begin tests_failed++; $display("FAIL clr_pre_irq: irq=%b required 1", irq_o); end
        count_i = 16'h44; trig_i = 1;
        repeat (2) @(negedge wb_clk_i);
        wb_write(A_CTRL, 32'h8000_0301, 4'hF);      // clear lands on the push edge
        trig_i = 0;
        repeat (3) @(negedge wb_clk_i);
        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h100) begin tests_failed++; $display("FAIL clr_status: got %h required %h", rd, 32'h100); end
        tests_run++;
        if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL clr_irq: irq=%b required 0", irq_o); end
        wb_read(A_CTRL, rd);
        tests_run++;
        if (rd !== 32'h301) begin tests_failed++; $display("FAIL clr_selfclear: got %h required %h", rd, 32'h301); end
        trig_event(16'h55);
        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h001) begin tests_failed++; $display("FAIL clr_post_status: got %h required %h", rd, 32'h001); end
        wb_read(A_DATA, rd);
        tests_run++;
        if (rd !== 32'h55) begin tests_failed++; $display("FAIL clr_post_data: got %h required %h", rd, 32'h55); end
    endtask

    task automatic test_edge_enable_sel();
        logic [31:0] rd;
        wb_write(A_CTRL, 32'h0000_0003, 4'hF);      // en, falling, thresh=0
        trig_event(16'h77);
        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h001) begin tests_failed++; $display("FAIL falling_status: got %h required %h", rd, 32'h001); end
        wb_read(A_DATA, rd);
        tests_run++;
        if (rd !== 32'h77) begin tests_failed++; $display("FAIL falling_data: got %h required %h", rd, 32'h77); end
        wb_write(A_CTRL, 32'h0000_0000, 4'hF);      // disabled
        trig_event(16'h88);
        wb_read(A_STATUS, rd);
        tests_run++;
        if (rd !== 32'h100) begin tests_failed++; $display("FAIL disabled_status: got %h required %h", rd, 32'h100); end
        wb_read(A_LAST, rd);
        tests_run++;
        if (rd !== 32'h77) begin tests_failed++; $display("FAIL disabled_last: got %h required %h", rd, 32'h77); end
        wb_write(A_CTRL, 32'hFFFF_FFFF, 4'b0010);   // only byte 1 (thresh) written
        wb_read(A_CTRL, rd);
        tests_run++;
        if (rd !== 32'h3F00) begin tests_failed++; $display("FAIL byte_sel_ctrl: got %h required %h", rd, 32'h3F00); end
    endtask

    initial begin
        wb_rst_ni = 0; count_i = '0; trig_i = 0;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;

        test_reset();
        test_single_capture();
        test_overflow_underflow();
        test_full_push_pop();
        test_irq_threshold();
        test_clear_coincident();
        test_edge_enable_sel();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
